// File: rtl/icache_dataram_rd_ctrl_if.sv
// Request/SRAM/response bundle between the icache tag stage, refill path, data SRAM and fetch unit.
// master = environment side (tag stage, refill, SRAM macro, fetch); slave = the read controller.
interface icache_dataram_rd_ctrl_if #(
  parameter int INDEX_WIDTH = 6,
  parameter int TXNID_WIDTH = 5,
  parameter int LINE_WIDTH  = 512,
  parameter int FIFO_DEPTH  = 4
);
  localparam int CNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

  logic                   rd_vld;
  logic [INDEX_WIDTH-1:0] rd_index;
  logic                   rd_way;
  logic [TXNID_WIDTH-1:0] rd_txnid;
  logic                   dataram_rd_rdy;

  logic                   wr_vld;
  logic                   wr_rdy;
  logic [INDEX_WIDTH-1:0] wr_index;
  logic                   wr_way;
  logic [LINE_WIDTH-1:0]  wr_data;

  logic                   ram_en;
  logic                   ram_wr_en;
  logic [INDEX_WIDTH:0]   ram_addr;
  logic [LINE_WIDTH-1:0]  ram_din;
  logic [LINE_WIDTH-1:0]  ram_dout;

  logic                   resp_vld;
  logic                   resp_rdy;
  logic [TXNID_WIDTH-1:0] resp_txnid;
  logic [LINE_WIDTH-1:0]  resp_data;
  logic [CNT_WIDTH-1:0]   fifo_cnt;
  logic [31:0]            resp_total;

  modport master (
    output rd_vld, rd_index, rd_way, rd_txnid,
    input  dataram_rd_rdy,
    output wr_vld, wr_index, wr_way, wr_data,
    input  wr_rdy,
    input  ram_en, ram_wr_en, ram_addr, ram_din,
    output ram_dout,
    input  resp_vld, resp_txnid, resp_data, fifo_cnt, resp_total,
    output resp_rdy
  );

  modport slave (
    input  rd_vld, rd_index, rd_way, rd_txnid,
    output dataram_rd_rdy,
    input  wr_vld, wr_index, wr_way, wr_data,
    output wr_rdy,
    output ram_en, ram_wr_en, ram_addr, ram_din,
    input  ram_dout,
    output resp_vld, resp_txnid, resp_data, fifo_cnt, resp_total,
    input  resp_rdy
  );
endinterface

// File: rtl/icache_dataram_rd_ctrl.sv
// Arbitrates linefill writes (priority) and hit reads onto a 1-cycle data SRAM; read fire in T -> resp_vld in T+2.
// Read credit withheld while a write is pending or FIFO+stage1 would overflow; resp_rdy low simply holds the FIFO.
module icache_dataram_rd_ctrl #(
  parameter int INDEX_WIDTH = 6,
  parameter int TXNID_WIDTH = 5,
  parameter int LINE_WIDTH  = 512,
  parameter int FIFO_DEPTH  = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  icache_dataram_rd_ctrl_if.slave bus
);
  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam int SUM_WIDTH = CNT_WIDTH + 1;
  localparam logic [SUM_WIDTH-1:0] DEPTH_LIM = SUM_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(FIFO_DEPTH);

  logic                   s1_vld;
  logic [TXNID_WIDTH-1:0] s1_txnid;
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [31:0]            total;
  logic [TXNID_WIDTH-1:0] txnid_mem [FIFO_DEPTH];
  logic [LINE_WIDTH-1:0]  data_mem  [FIFO_DEPTH];

  logic credit;
  logic rd_fire;
  logic push;
  logic pop;
  logic empty;
  logic full;

  // Stage-1 read counts against capacity; a same-cycle pop does not, keeping rdy free of resp_rdy.
  assign credit  = !bus.wr_vld && (({1'b0, cnt} + SUM_WIDTH'(s1_vld)) < DEPTH_LIM);
  assign rd_fire = bus.rd_vld && credit;

  assign bus.dataram_rd_rdy = credit;
  assign bus.wr_rdy         = 1'b1;
  assign bus.ram_din        = bus.wr_data;

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_wr_en = 1'b0;
    bus.ram_addr  = {bus.rd_way, bus.rd_index};
    if (bus.wr_vld) begin
      bus.ram_en    = 1'b1;
      bus.ram_wr_en = 1'b1;
      bus.ram_addr  = {bus.wr_way, bus.wr_index};
    end else if (rd_fire) begin
      bus.ram_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_txnid <= '0;
    end else begin
      s1_vld <= rd_fire;
      if (rd_fire) begin
        s1_txnid <= bus.rd_txnid;
      end
    end
  end

  assign empty = (cnt == '0);
  assign full  = (cnt == DEPTH_CNT);
  assign push  = s1_vld;
  assign pop   = !empty && bus.resp_rdy;

  // Payload needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (push) begin
      txnid_mem[wr_ptr] <= s1_txnid;
      data_mem[wr_ptr]  <= bus.ram_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      total  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_WIDTH'(1);
        total  <= total + 32'd1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_WIDTH'(1);
        2'b01:   cnt <= cnt - CNT_WIDTH'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign bus.resp_vld   = !empty;
  assign bus.resp_txnid = txnid_mem[rd_ptr];
  assign bus.resp_data  = data_mem[rd_ptr];
  assign bus.fifo_cnt   = cnt;
  assign bus.resp_total = total;

`ifndef SYNTHESIS
  a_no_push_full:  assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_pop_empty:  assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
  a_wr_implies_en: assert property (@(posedge clk) disable iff (!rst_n) !(bus.ram_wr_en && !bus.ram_en));
  a_no_rd_and_wr:  assert property (@(posedge clk) disable iff (!rst_n) !(rd_fire && bus.wr_vld));
`endif
endmodule
